// File: rtl/pll_lock_ctrl_if.sv
// PLL supervisor bus: PLL lock input and the reset/status outputs.
// master: the lock controller. slave: the PLL / system side.
interface pll_lock_ctrl_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       lock_ok;
    logic [7:0] lock_loss_cnt;
    logic       retry_fail;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst,
        output lock_ok,
        output lock_loss_cnt,
        output retry_fail
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst,
        input  lock_ok,
        input  lock_loss_cnt,
        input  retry_fail
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: holds the PLL in reset, qualifies lock, releases the
// system reset after stable lock, re-arms on loss and gives up after a bounded
// number of failed attempts.
// Optional build macro PLL_LOCK_CTRL_GLITCH_FILTER_EN: in RUN, lock loss is
// only declared after 4 consecutive unlocked cycles.
module pll_lock_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 4,
    parameter int unsigned CNT_W         = 20
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_ctrl_if.master       ctrl_if
);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_e;

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RetryLast   = 8'(MAX_RETRY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             lock_ok_q, lock_ok_d;
    logic             retry_fail_q, retry_fail_d;
    logic             lk;
    logic             lk_lost;
    logic             attempt_fail;

    assign lk = sync2_q;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ctrl_if.pll_locked;
            sync2_q <= sync1_q;
        end
    end

`ifdef PLL_LOCK_CTRL_GLITCH_FILTER_EN
    logic [1:0] flt_q, flt_d;

    // Count consecutive unlocked RUN cycles; any locked cycle restarts it
    always_comb begin
        flt_d = 2'd0;
        if (state_q == StRun && !lk) begin
            flt_d = flt_q + 2'd1;
        end
    end

    // Filter counter register
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            flt_q <= 2'd0;
        end else begin
            flt_q <= flt_d;
        end
    end

    // Fourth consecutive unlocked cycle is a real loss
    assign lk_lost = !lk && (flt_q == 2'd3);
`else
    assign lk_lost = !lk;
`endif

    // Next-state logic; outputs are decoded from the next state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        loss_d       = loss_q;
        attempt_fail = 1'b0;

        unique case (state_q)
            StResetPll: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                // Lock takes priority over a coincident timeout
                if (lk) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    attempt_fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStable: begin
                // Loss takes priority over a coincident completion
                if (!lk) begin
                    attempt_fail = 1'b1;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (lk_lost) begin
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                    // A fresh loss earns a full retry budget
                    retry_d = 8'd0;
                    state_d = StResetPll;
                    cnt_d   = '0;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StFail;
            end
        endcase

        if (attempt_fail) begin
            if (retry_q == RetryLast) begin
                state_d = StFail;
            end else begin
                retry_d = retry_q + 8'd1;
                state_d = StResetPll;
                cnt_d   = '0;
            end
        end

        pll_rst_d    = (state_d == StResetPll) || (state_d == StFail);
        sys_rst_d    = (state_d != StRun);
        lock_ok_d    = (state_d == StRun);
        retry_fail_d = (state_d == StFail);
    end

    // State, counters and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= StResetPll;
            cnt_q        <= '0;
            retry_q      <= 8'd0;
            loss_q       <= 8'd0;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            lock_ok_q    <= 1'b0;
            retry_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_rst_q    <= pll_rst_d;
            sys_rst_q    <= sys_rst_d;
            lock_ok_q    <= lock_ok_d;
            retry_fail_q <= retry_fail_d;
        end
    end

    assign ctrl_if.pll_rst       = pll_rst_q;
    assign ctrl_if.sys_rst       = sys_rst_q;
    assign ctrl_if.lock_ok       = lock_ok_q;
    assign ctrl_if.lock_loss_cnt = loss_q;
    assign ctrl_if.retry_fail    = retry_fail_q;

endmodule
